// File: rtl/lii_tx_mux.sv
// Round-robin merge of NS kernel streams onto one LII phy channel via a 2-entry output FIFO.
// Define LII_TX_BURST_LOCK_EN to hold the grant on a stream until its s_tlast beat is accepted.

module lii_tx_mux_lane #(
    parameter int RW  = 1,
    parameter int IDX = 0
) (
    input  logic [RW-1:0] sel_idx,
    input  logic          sel_vld,
    input  logic          vld,
    input  logic          space,
    output logic          rdy
);
    assign rdy = sel_vld && (sel_idx == RW'(IDX)) && vld && space;
endmodule

module lii_tx_mux #(
    parameter int         NS     = 2,
    parameter int         PW     = 1024,
    parameter logic [7:0] SRC_ID = 8'h00
) (
    input  logic           aclk,
    input  logic           arstn,
    input  logic [NS*PW-1:0] s_tdata,
    input  logic [NS-1:0]  s_tvalid,
    output logic [NS-1:0]  s_tready,
    input  logic [NS-1:0]  s_tlast,
    input  logic [NS*8-1:0] s_dst,
    output logic [PW-1:0]  lii_out_p0_tdata,
    output logic           lii_out_p0_tvalid,
    input  logic           lii_out_p0_tready,
    output logic [7:0]     lii_out_p0_src,
    output logic [7:0]     lii_out_p0_dst,
    output logic [31:0]    beat_cnt
);
    localparam int RW = (NS > 1) ? $clog2(NS) : 1;

    typedef struct packed {
        logic [PW-1:0] tdata;
        logic [7:0]    dst;
    } beat_t;

    logic [NS-1:0][PW-1:0] lane_data;
    logic [NS-1:0][7:0]    lane_dst;
    assign lane_data = s_tdata;
    assign lane_dst  = s_dst;

    logic [RW-1:0] rr;
    logic [RW-1:0] rr_grant, idx_w, grant;
    logic          rr_vld, grant_vld;
    logic [1:0]    count;
    logic          wr_ptr, rd_ptr;
    logic          space, push, pop;
    beat_t         mem [2];
    beat_t         head;

    // First valid stream after the last granted one, wrapping modulo NS.
    always_comb begin
        rr_grant = '0;
        rr_vld   = 1'b0;
        idx_w    = '0;
        for (int k = 1; k <= NS; k++) begin
            idx_w = RW'((int'(rr) + k) % NS);
            if (!rr_vld && s_tvalid[idx_w]) begin
                rr_grant = idx_w;
                rr_vld   = 1'b1;
            end
        end
    end

`ifdef LII_TX_BURST_LOCK_EN
    logic          locked;
    logic [RW-1:0] lock_id;

    assign grant     = locked ? lock_id : rr_grant;
    assign grant_vld = locked ? s_tvalid[lock_id] : rr_vld;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rr      <= RW'(NS - 1);
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (push) begin
            if (s_tlast[grant]) begin
                locked <= 1'b0;
                rr     <= grant;
            end else begin
                locked  <= 1'b1;
                lock_id <= grant;
            end
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = ^s_tlast;
    assign grant        = rr_grant;
    assign grant_vld    = rr_vld;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            rr <= RW'(NS - 1);
        else if (push)
            rr <= grant;
    end
`endif

    assign space = (count < 2'd2);
    assign push  = grant_vld && space;
    assign pop   = lii_out_p0_tvalid && lii_out_p0_tready;

    for (genvar i = 0; i < NS; i++) begin : g_lane
        lii_tx_mux_lane #(.RW(RW), .IDX(i)) u_lane (
            .sel_idx (grant),
            .sel_vld (grant_vld),
            .vld     (s_tvalid[i]),
            .space   (space),
            .rdy     (s_tready[i])
        );
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is left unreset; count alone decides what is valid.
    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= '{tdata: lane_data[grant], dst: lane_dst[grant]};
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            beat_cnt <= 32'd0;
        else if (pop)
            beat_cnt <= beat_cnt + 32'd1;
    end

    assign head              = mem[rd_ptr];
    assign lii_out_p0_tvalid = (count != 2'd0);
    assign lii_out_p0_tdata  = head.tdata;
    assign lii_out_p0_dst    = head.dst;
    assign lii_out_p0_src    = SRC_ID;
endmodule

// File: tb/tb_lii_tx_mux.sv
// Bench for lii_tx_mux: directed vector table, burst/reset/wrap sequences, random run vs queue model.

module tb_lii_tx_mux;
    localparam int NS = 2;
    localparam int PW = 32;
    localparam logic [7:0] SID = 8'h5A;

    logic            aclk = 1'b0;
    logic            arstn;
    logic [NS*PW-1:0] s_tdata;
    logic [NS-1:0]   s_tvalid, s_tready, s_tlast;
    logic [NS*8-1:0] s_dst;
    logic [PW-1:0]   o_tdata;
    logic            o_tvalid, o_tready;
    logic [7:0]      o_src, o_dst;
    logic [31:0]     beat_cnt;

    lii_tx_mux #(.NS(NS), .PW(PW), .SRC_ID(SID)) dut (
        .aclk              (aclk),
        .arstn             (arstn),
        .s_tdata           (s_tdata),
        .s_tvalid          (s_tvalid),
        .s_tready          (s_tready),
        .s_tlast           (s_tlast),
        .s_dst             (s_dst),
        .lii_out_p0_tdata  (o_tdata),
        .lii_out_p0_tvalid (o_tvalid),
        .lii_out_p0_tready (o_tready),
        .lii_out_p0_src    (o_src),
        .lii_out_p0_dst    (o_dst),
        .beat_cnt          (beat_cnt)
    );

    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        arstn    = 1'b0;
        s_tvalid = '0;
        o_tready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  tv;
        logic        tr;
        logic [1:0]  rdy;
        logic        v;
        logic [31:0] d;
        logic [7:0]  dst;
        logic [31:0] bc;
    } vec_t;
    vec_t tbl[14];

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dst;
    } mbeat_t;
    mbeat_t q[$];
    int          m_rr, m_locked, m_lid;
    logic [31:0] m_bc;

    function automatic int m_grant(input logic [1:0] tv);
        if (m_locked != 0) return tv[m_lid] ? m_lid : -1;
        for (int k = 1; k <= NS; k++) begin
            int idx;
            idx = (m_rr + k) % NS;
            if (tv[idx]) return idx;
        end
        return -1;
    endfunction

    int exp_burst[4];
    int got, s1_cnt, g;
    logic [1:0] exp_rdy;

    initial begin
        // Directed sequence from reset: alternation, 1-cycle latency, backpressure, drain.
        tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, 32'h0,  8'h00, 32'd0};
        tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 32'hA5, 8'h03, 32'd0};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 32'hB6, 8'h07, 32'd1};
        tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 32'hA5, 8'h03, 32'd2};
        tbl[4]  = '{2'b00, 1'b1, 2'b00, 1'b1, 32'hB6, 8'h07, 32'd3};
        tbl[5]  = '{2'b00, 1'b1, 2'b00, 1'b0, 32'h0,  8'h00, 32'd4};
        tbl[6]  = '{2'b11, 1'b0, 2'b01, 1'b0, 32'h0,  8'h00, 32'd4};
        tbl[7]  = '{2'b11, 1'b0, 2'b10, 1'b1, 32'hA5, 8'h03, 32'd4};
        tbl[8]  = '{2'b11, 1'b0, 2'b00, 1'b1, 32'hA5, 8'h03, 32'd4};
        tbl[9]  = '{2'b11, 1'b0, 2'b00, 1'b1, 32'hA5, 8'h03, 32'd4};
        tbl[10] = '{2'b11, 1'b0, 2'b00, 1'b1, 32'hA5, 8'h03, 32'd4};
        tbl[11] = '{2'b00, 1'b1, 2'b00, 1'b1, 32'hA5, 8'h03, 32'd4};
        tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b1, 32'hB6, 8'h07, 32'd5};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b0, 32'h0,  8'h00, 32'd6};

        s_tdata = {32'h0000_00B6, 32'h0000_00A5};
        s_dst   = {8'h07, 8'h03};
        s_tlast = 2'b11;
        arstn   = 1'b0;
        s_tvalid = '0;
        o_tready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_bcnt", beat_cnt, 0);
        check("rst_tready", s_tready, 0);
        arstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            s_tvalid = tbl[i].tv;
            o_tready = tbl[i].tr;
            #1;
            check($sformatf("vec%0d_rdy", i), s_tready, tbl[i].rdy);
            check($sformatf("vec%0d_vld", i), o_tvalid, tbl[i].v);
            check($sformatf("vec%0d_bcnt", i), beat_cnt, tbl[i].bc);
            if (tbl[i].v) begin
                check($sformatf("vec%0d_data", i), o_tdata, tbl[i].d);
                check($sformatf("vec%0d_dst", i), o_dst, tbl[i].dst);
                check($sformatf("vec%0d_src", i), o_src, SID);
            end
            @(negedge aclk);
        end

        // Counter wrap: preload all-ones, then exactly one transfer.
        s_tvalid = '0;
        o_tready = 1'b1;
        force dut.beat_cnt = 32'hFFFF_FFFF;
        @(negedge aclk);
        release dut.beat_cnt;
        #1;
        check("wrap_pre", beat_cnt, 32'hFFFF_FFFF);
        s_tvalid = 2'b01;
        @(negedge aclk);
        s_tvalid = 2'b00;
        @(negedge aclk);
        #1;
        check("wrap_post", beat_cnt, 32'd0);
        check("wrap_empty", o_tvalid, 0);

        // Burst: stream 1 sends 3 beats (last on the 3rd) while stream 0 stays valid.
`ifdef LII_TX_BURST_LOCK_EN
        exp_burst = '{1, 1, 1, 0};
`else
        exp_burst = '{1, 0, 1, 0};
`endif
        do_reset();
        o_tready = 1'b1;
        s_tlast  = 2'b11;
        s_tvalid = 2'b01;
        @(negedge aclk);
        s1_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            s_tvalid = 2'b11;
            s_tlast  = {(s1_cnt == 2), 1'b1};
            #1;
            got = s_tready[1] ? 1 : (s_tready[0] ? 0 : 9);
            check($sformatf("burst%0d_grant", c), got, exp_burst[c]);
            if (s_tready[1]) s1_cnt++;
            @(negedge aclk);
        end
        s_tvalid = 2'b00;
        s_tlast  = 2'b11;
        repeat (3) @(negedge aclk);

        // Reset with two beats buffered after stream-0 grants.
        do_reset();
        o_tready = 1'b0;
        s_tvalid = 2'b01;
        #1;
        check("rstmid_acc0", s_tready, 2'b01);
        @(negedge aclk);
        #1;
        check("rstmid_acc1", s_tready, 2'b01);
        @(negedge aclk);
        s_tvalid = 2'b00;
        #1;
        check("rstmid_full", o_tvalid, 1);
        #2;
        arstn = 1'b0;
        #1;
        check("rstmid_async", o_tvalid, 0);
        @(negedge aclk);
        arstn    = 1'b1;
        o_tready = 1'b1;
        s_tvalid = 2'b11;
        #1;
        check("rstmid_first", s_tready, 2'b01);
        check("rstmid_empty", o_tvalid, 0);
        @(negedge aclk);
        s_tvalid = 2'b00;
        repeat (2) @(negedge aclk);

        // Random traffic against the queue model.
        do_reset();
        q.delete();
        m_rr = NS - 1;
        m_locked = 0;
        m_lid = 0;
        m_bc = 0;
        for (int c = 0; c < 600; c++) begin
            s_tvalid = 2'($urandom);
            s_tlast  = 2'($urandom);
            o_tready = ($urandom_range(0, 3) != 0);
            s_tdata  = {$urandom, $urandom};
            s_dst    = 16'($urandom);
            #1;
            g = m_grant(s_tvalid);
            exp_rdy = (g >= 0 && q.size() < 2) ? (2'b01 << g) : 2'b00;
            check("rnd_rdy", s_tready, exp_rdy);
            check("rnd_vld", o_tvalid, q.size() > 0);
            check("rnd_bcnt", beat_cnt, m_bc);
            if (q.size() > 0) begin
                check("rnd_data", o_tdata, q[0].d);
                check("rnd_dst", o_dst, q[0].dst);
            end
            if (q.size() > 0 && o_tready) begin
                void'(q.pop_front());
                m_bc++;
            end
            if (exp_rdy != 2'b00) begin
                q.push_back('{s_tdata[g*PW +: PW], s_dst[g*8 +: 8]});
`ifdef LII_TX_BURST_LOCK_EN
                if (s_tlast[g]) begin
                    m_locked = 0;
                    m_rr = g;
                end else begin
                    m_locked = 1;
                    m_lid = g;
                end
`else
                m_rr = g;
`endif
            end
            @(negedge aclk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lii_tx_mux.md
LII_TX_MUX -- requirements
Module: lii_tx_mux

Interface
- REQ-001: Parameter NS, default 2, number of logical kernel output streams merged onto one phy channel (1..8).
- REQ-002: Parameter PW, default 1024, LII packing width in bits.
- REQ-003: Parameter SRC_ID, default 8'h00, node id driven on lii_out_p0_src.
- REQ-004: Port aclk  input  1  sole clock; all state on its rising edge.
- REQ-005: Port arstn  input  1  asynchronous active-low reset.
- REQ-006: Port s_tdata  input  NS*PW  stream i payload at bits [i*PW +: PW].
- REQ-007: Port s_tvalid  input  NS  per-stream valid.
- REQ-008: Port s_tready  output  NS  per-stream ready.
- REQ-009: Port s_tlast  input  NS  per-stream end-of-burst marker.
- REQ-010: Port s_dst  input  NS*8  stream i destination id at bits [i*8 +: 8].
- REQ-011: Port lii_out_p0_tdata  output  PW  phy payload.
- REQ-012: Port lii_out_p0_tvalid  output  1  phy valid.
- REQ-013: Port lii_out_p0_tready  input  1  phy ready.
- REQ-014: Port lii_out_p0_src  output  8  source id, equal to SRC_ID on every beat.
- REQ-015: Port lii_out_p0_dst  output  8  destination id of the current beat.
- REQ-016: Port beat_cnt  output  32  count of phy beats transferred.

Function
- REQ-017: Output path SHALL be a 2-entry FIFO of {tdata, dst}; lii_out_p0_tvalid = (count != 0); head entry drives the outputs.
- REQ-018: A beat transfers on the phy when lii_out_p0_tvalid && lii_out_p0_tready; outputs SHALL stay stable while tvalid=1 and tready=0.
- REQ-019: The FIFO SHALL accept a beat only when count < 2, where count is registered state; count == 1 with simultaneous push and pop leaves count at 1.
- REQ-020: Round-robin pointer rr (last granted index): on each cycle, search from rr+1 mod NS upward for the first asserted s_tvalid; that stream is granted.
- REQ-021: s_tready[i] = (i == grant) && s_tvalid[i] && (count < 2); all other s_tready bits 0.
- REQ-022: On an accepted beat, rr <= grant, and the FIFO pushes {s_tdata[grant], s_dst[grant]}.
- REQ-023: Latency from input acceptance to lii_out_p0_tvalid SHALL be exactly 1 cycle when the FIFO is empty.
- REQ-024: Sustained throughput SHALL be 1 beat/cycle when lii_out_p0_tready is held at 1.
- REQ-025: beat_cnt increments by 1 per phy transfer and wraps from 2^32-1 to 0.
- REQ-026: No s_tvalid asserted -> no grant, all s_tready 0, rr unchanged.

Reset
- REQ-027: arstn low SHALL asynchronously clear count to 0 (lii_out_p0_tvalid=0), set rr to NS-1 (stream 0 first priority), clear beat_cnt to 0, and clear the burst lock.
- REQ-028: Reset mid-transfer SHALL drop buffered beats; FIFO data registers need not be cleared.
- REQ-029: The first grant after reset release SHALL be no earlier than the first rising edge with arstn high.

Configuration
- REQ-030: Macro LII_TX_BURST_LOCK_EN defined: after accepting a beat with s_tlast=0 from stream i, grant SHALL stay locked on i (all other s_tready 0) until a beat with s_tlast=1 from i is accepted; rr updates only at burst end.
- REQ-031: Macro undefined: s_tlast is ignored and arbitration occurs on every beat.

Verification
- REQ-032: Reset, then s_tvalid=2'b11 and tready=1 held -> phy order stream 0,1,0,1; one beat per cycle; beat_cnt=4 after 4 cycles.
- REQ-033: Stream 0 single beat with data=0xA5 and dst=8'h03 into an empty FIFO -> cycle+1: tvalid=1, tdata=0xA5, dst=8'h03, src=SRC_ID.
- REQ-034: tready=0 for 5 cycles while both streams are valid -> exactly 2 beats accepted, s_tready=0 afterwards, outputs stable; on tready=1 the 2 beats drain in order.
- REQ-035: With LII_TX_BURST_LOCK_EN defined, stream 1 sends a 3-beat burst while stream 0 is valid -> 3 consecutive stream-1 beats, then stream 0; without the macro, the streams interleave.
- REQ-036: beat_cnt preloaded to 32'hFFFFFFFF via force, then one transfer -> beat_cnt=0.
- REQ-037: arstn pulsed low with 2 beats buffered -> tvalid=0 immediately; after release, stream 0 is granted first.
